// File: rtl/fir_coef_tx.sv
// Coefficient transmitter for a serial-coefficient FIR datapath: sends a one-word
// preamble and NTAP table words, then paces incoming samples at most once per SPACING cycles.
module fir_coef_tx #(
  parameter int NTAP    = 64,
  parameter int SPACING = 64
) (
  input  logic        clk,
  input  logic        TX_restn,
  input  logic        cfg_we,
  input  logic [5:0]  cfg_addr,
  input  logic [15:0] cfg_data,
  input  logic        start,
  input  logic        s_valid,
  input  logic [15:0] s_data,
  output logic        s_ready,
  output logic [15:0] b,
  output logic [15:0] x,
  output logic        b_valid,
  output logic        busy,
  output logic        coef_done
);

  localparam int KW = (NTAP > 1) ? $clog2(NTAP) : 1;
  localparam int CW = (SPACING > 1) ? $clog2(SPACING) : 1;

  typedef enum logic [1:0] {IDLE, PREAMBLE, LOAD, STREAM} state_t;

  state_t        state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0]   b_q, b_d;
  logic [15:0]   x_q, x_d;
  logic          bv_q, bv_d;
  logic          done_q, done_d;
  logic          ready;

  logic [15:0]   coef_q [NTAP];
  logic          coef_we;
  logic [KW-1:0] wr_idx;

  // The table only accepts writes while idle so a load in flight streams a stable snapshot.
  assign wr_idx  = cfg_addr[KW-1:0];
  assign coef_we = (state_q == IDLE) && cfg_we && (int'(cfg_addr) < NTAP);

  generate
    for (genvar gi = 0; gi < NTAP; gi++) begin : g_coef
      always_ff @(posedge clk or negedge TX_restn) begin
        if (!TX_restn) begin
          coef_q[gi] <= '0;
        end else if (coef_we && (wr_idx == KW'(gi))) begin
          coef_q[gi] <= cfg_data;
        end
      end
    end
  endgenerate

  assign ready = (state_q == STREAM) && (cnt_q == '0);

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    cnt_d   = cnt_q;
    b_d     = b_q;
    x_d     = x_q;
    bv_d    = 1'b0;
    done_d  = done_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = PREAMBLE;
          b_d     = '0;
          k_d     = '0;
        end
      end
      PREAMBLE: begin
        state_d = LOAD;
        k_d     = '0;
        b_d     = coef_q[0];
      end
      LOAD: begin
        if (k_q == KW'(NTAP - 1)) begin
          state_d = STREAM;
          b_d     = '0;
          done_d  = 1'b1;
          cnt_d   = '0;
        end else begin
          k_d = k_q + 1'b1;
          b_d = coef_q[k_d];
        end
      end
      STREAM: begin
        // A slot at count zero is held until a sample arrives rather than skipped.
        if (ready && s_valid) begin
          x_d   = s_data;
          bv_d  = 1'b1;
          cnt_d = CW'(1);
        end else if (cnt_q != '0) begin
          cnt_d = (cnt_q == CW'(SPACING - 1)) ? '0 : cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge TX_restn) begin
    if (!TX_restn) begin
      state_q <= IDLE;
      k_q     <= '0;
      cnt_q   <= '0;
      b_q     <= '0;
      x_q     <= '0;
      bv_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      cnt_q   <= cnt_d;
      b_q     <= b_d;
      x_q     <= x_d;
      bv_q    <= bv_d;
      done_q  <= done_d;
    end
  end

  assign s_ready   = ready;
  assign b         = b_q;
  assign x         = x_q;
  assign b_valid   = bv_q;
  assign busy      = (state_q != IDLE);
  assign coef_done = done_q;

endmodule

// File: tb/tb_fir_coef_tx.sv
// Bench for fir_coef_tx: a time-based reference model checked every cycle, plus
// directed vectors with literal expectations for load order, pacing and reset.
module tb_fir_coef_tx;
  localparam int NTAP    = 64;
  localparam int SPACING = 64;

  logic        clk = 1'b0;
  logic        TX_restn = 1'b0;
  logic        cfg_we = 1'b0;
  logic [5:0]  cfg_addr = '0;
  logic [15:0] cfg_data = '0;
  logic        start = 1'b0;
  logic        s_valid = 1'b0;
  logic [15:0] s_data = '0;
  logic        s_ready;
  logic [15:0] b;
  logic [15:0] x;
  logic        b_valid;
  logic        busy;
  logic        coef_done;

  int n_checks = 0;
  int n_fail   = 0;
  bit mon_en   = 1'b0;

  fir_coef_tx #(.NTAP(NTAP), .SPACING(SPACING)) dut (
    .clk(clk), .TX_restn(TX_restn), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data), .start(start), .s_valid(s_valid), .s_data(s_data),
    .s_ready(s_ready), .b(b), .x(x), .b_valid(b_valid), .busy(busy),
    .coef_done(coef_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: a pending-word queue for the load and the time of the last accepted sample.
  int          cyc = 0;
  bit          m_started = 1'b0;
  bit          m_done = 1'b0;
  bit          m_has_acc = 1'b0;
  int          m_last = 0;
  logic [15:0] m_q[$];
  logic [15:0] m_coef [NTAP];
  logic [15:0] e_b = '0;
  logic [15:0] e_x = '0;
  logic        e_bv = 1'b0;

  function automatic bit m_ready(input int edge_idx);
    return m_done && (!m_has_acc || (edge_idx - m_last >= SPACING));
  endfunction

  initial begin
    foreach (m_coef[i]) m_coef[i] = '0;
    forever begin
      @(posedge clk or negedge TX_restn);
      if (!TX_restn) begin
        foreach (m_coef[i]) m_coef[i] = '0;
        m_q.delete();
        m_started = 1'b0;
        m_done    = 1'b0;
        m_has_acc = 1'b0;
        e_b       = '0;
        e_x       = '0;
        e_bv      = 1'b0;
      end else begin
        cyc++;
        e_bv = 1'b0;
        if (!m_started) begin
          if (cfg_we) m_coef[cfg_addr] = cfg_data;
          if (start) begin
            m_started = 1'b1;
            e_b = '0;
            for (int i = 0; i < NTAP; i++) m_q.push_back(m_coef[i]);
          end
        end else if (m_q.size() > 0) begin
          e_b = m_q.pop_front();
        end else if (!m_done) begin
          m_done = 1'b1;
          e_b = '0;
        end else if (s_valid && m_ready(cyc)) begin
          e_x       = s_data;
          e_bv      = 1'b1;
          m_has_acc = 1'b1;
          m_last    = cyc;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        chk("model_b", 32'(b), 32'(e_b));
        chk("model_x", 32'(x), 32'(e_x));
        chk("model_b_valid", 32'(b_valid), 32'(e_bv));
        chk("model_busy", 32'(busy), 32'(m_started));
        chk("model_coef_done", 32'(coef_done), 32'(m_done));
        chk("model_s_ready", 32'(s_ready), 32'(m_ready(cyc + 1)));
        if (b_valid === 1'b1) $display("strobe: x=%h cycle=%0d", x, cyc);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int gap;
    int pulses;
    TX_restn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_b", 32'(b), 32'h0);
    chk("rst_x", 32'(x), 32'h0);
    chk("rst_b_valid", 32'(b_valid), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_coef_done", 32'(coef_done), 32'h0);
    chk("rst_s_ready", 32'(s_ready), 32'h0);
    mon_en   = 1'b1;
    TX_restn = 1'b1;

    for (int i = 0; i < NTAP; i++) begin
      cfg_we = 1'b1; cfg_addr = 6'(i); cfg_data = 16'(i + 1);
      tick();
    end
    cfg_we = 1'b0;
    $display("load: table written with 1..64");

    start = 1'b1;
    tick();
    start = 1'b0;
    chk("preamble_busy", 32'(busy), 32'h1);
    chk("preamble_b", 32'(b), 32'h0);

    // Writes attempted during the load must not disturb the table or the stream.
    cfg_we = 1'b1; cfg_data = 16'hFFFF;
    for (int k = 0; k < NTAP; k++) begin
      cfg_addr = 6'(k);
      tick();
      chk("load_word", 32'(b), 32'(k + 1));
    end
    cfg_we = 1'b0;
    tick();
    chk("stream_coef_done", 32'(coef_done), 32'h1);
    chk("stream_b", 32'(b), 32'h0);
    chk("stream_s_ready", 32'(s_ready), 32'h1);

    s_valid = 1'b1; s_data = 16'h0100;
    tick();
    chk("first_bv", 32'(b_valid), 32'h1);
    chk("first_x", 32'(x), 32'h0100);
    s_data = 16'h0200;
    gap = 0;
    for (int n = 1; n <= 200; n++) begin
      start = (n == 10);
      tick();
      if (b_valid) begin
        gap = n;
        break;
      end
    end
    start = 1'b0;
    s_valid = 1'b0;
    chk("strobe_gap", 32'(gap), 32'd64);
    chk("second_x", 32'(x), 32'h0200);
    chk("start_in_stream_b", 32'(b), 32'h0);

    repeat (100) tick();
    s_valid = 1'b1; s_data = 16'h7FFF;
    tick();
    chk("late_bv", 32'(b_valid), 32'h1);
    chk("late_x", 32'(x), 32'h7FFF);
    s_valid = 1'b0;
    pulses = 0;
    repeat (70) begin
      tick();
      if (b_valid) pulses++;
    end
    chk("late_single_pulse", 32'(pulses), 32'h0);
    chk("late_x_hold", 32'(x), 32'h7FFF);

    TX_restn = 1'b0;
    tick();
    TX_restn = 1'b1;
    for (int i = 0; i < NTAP; i++) begin
      cfg_we = 1'b1; cfg_addr = 6'(i); cfg_data = 16'(i + 1);
      tick();
    end
    cfg_we = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (31) tick();
    chk("word30_b", 32'(b), 32'd31);
    #1;
    TX_restn = 1'b0;
    #1;
    chk("abort_b", 32'(b), 32'h0);
    chk("abort_busy", 32'(busy), 32'h0);
    chk("abort_coef_done", 32'(coef_done), 32'h0);
    chk("abort_b_valid", 32'(b_valid), 32'h0);
    chk("abort_x", 32'(x), 32'h0);
    $display("abort: reset asserted at load word 30");
    @(posedge clk);
    #1;
    TX_restn = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("reload_word0", 32'(b), 32'h0);
    repeat (63) tick();
    chk("reload_word63", 32'(b), 32'h0);
    tick();
    chk("reload_coef_done", 32'(coef_done), 32'h1);
    repeat (3) tick();

    mon_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fir_coef_tx.md
FIR_COEF_TX -- requirements
Module: fir_coef_tx

Interface
REQ-001 SHALL have parameter NTAP, default 64, number of coefficients sent per load.
REQ-002 SHALL have parameter SPACING, default 64, minimum clock cycles between successive sample strobes (must be ≥2).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port TX_restn  input  1  reset; asynchronous and active-low.
REQ-005 SHALL have port cfg_we  input  1  coefficient-table write enable.
REQ-006 SHALL have port cfg_addr  input  6  coefficient-table index 0..NTAP-1.
REQ-007 SHALL have port cfg_data  input  16  signed coefficient write data.
REQ-008 SHALL have port start  input  1  single-cycle request to begin a coefficient load.
REQ-009 SHALL have port s_valid  input  1  upstream sample available.
REQ-010 SHALL have port s_data  input  16  signed upstream sample.
REQ-011 SHALL have port s_ready  output  1  sample accepted this cycle when high with s_valid.
REQ-012 SHALL have port b  output  16  signed serial coefficient stream to the filter datapath.
REQ-013 SHALL have port x  output  16  signed sample to the filter datapath.
REQ-014 SHALL have port b_valid  output  1  one-cycle strobe marking x as a new sample.
REQ-015 SHALL have port busy  output  1  high in any state except IDLE.
REQ-016 SHALL have port coef_done  output  1  high once all NTAP coefficients have been sent.

Function
REQ-017 SHALL hold an NTAP x 16 coefficient table written when cfg_we=1 in IDLE; writes in other states are ignored.
REQ-018 SHALL implement states IDLE, PREAMBLE, LOAD, STREAM.
REQ-019 IDLE -> PREAMBLE SHALL occur on the clock edge where start=1; start is ignored outside IDLE.
REQ-020 PREAMBLE SHALL last exactly 1 cycle with b=0 (the filter datapath discards its first post-reset word), then go to LOAD.
REQ-021 LOAD SHALL drive b=coef[k] for k=0..NTAP-1, one word per cycle, in index order, then go to STREAM.
REQ-022 b, x, b_valid SHALL be registered outputs; b changes on the edge that enters/advances each word.
REQ-023 coef_done SHALL rise on the edge entering STREAM and stay high until reset.
REQ-024 b SHALL return to 0 and hold in STREAM.
REQ-025 In STREAM, a spacing counter SHALL count 0..SPACING-1; s_ready SHALL be combinationally high only when counter==0.
REQ-026 On s_valid&&s_ready, x SHALL load s_data, b_valid SHALL pulse high for the next cycle only, and the counter SHALL advance to 1.
REQ-027 With counter==0 and s_valid=0, counter SHALL hold at 0 (no skipped slot, b_valid stays 0).
REQ-028 Counter at SPACING-1 SHALL wrap to 0; consecutive b_valid pulses SHALL therefore be ≥SPACING cycles apart.
REQ-029 x SHALL hold its last value between strobes.
REQ-030 STREAM SHALL be terminal; only reset returns to IDLE.
REQ-031 s_ready SHALL be 0 in IDLE, PREAMBLE, LOAD.

Reset
REQ-032 While TX_restn=0: state=IDLE, b=0, x=0, b_valid=0, coef_done=0, busy=0, counters=0, immediately (asynchronous).
REQ-033 Coefficient table contents SHALL be cleared to 0 by reset.
REQ-034 Reset asserted mid-LOAD or mid-STREAM SHALL abort immediately; a new start is required after release.

Verification
REQ-035 Write coef[i]=i+1 for i=0..63, pulse start -> busy next cycle, b=0 for 1 cycle, then b=1,2,...,64 on 64 consecutive cycles, coef_done high after.
REQ-036 In STREAM, s_valid held high with s_data=0x0100,0x0200 -> b_valid pulses exactly 64 cycles apart, x=0x0100 then 0x0200.
REQ-037 s_valid low for 100 cycles in STREAM then high with 0x7FFF -> accepted on first valid cycle, x=0x7FFF, single b_valid pulse.
REQ-038 cfg_we=1 during LOAD with cfg_data=0xFFFF -> table unchanged, streamed words unaffected.
REQ-039 TX_restn low at LOAD word 30 -> all outputs 0 within same cycle, state IDLE, coef_done=0; re-load after start resumes from word 0 with b=0 (cleared table).
REQ-040 start pulsed during STREAM -> no effect, b stays 0, pacing unchanged.
